// File: rtl/bcd2binary_seq_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_e     : converter FSM states (IDLE, CONV, DONE)
//   DIGIT_W     : width of one BCD digit
//   ADJ_THRESH  : a digit at or above this value is adjusted after each shift
//   ADJ_VAL     : amount subtracted from an adjusted digit
//   cnt_width() : width of the iteration counter for a given result width
// -----------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DIGIT_W    = 4;
   localparam int ADJ_THRESH = 8;
   localparam int ADJ_VAL    = 3;

   // The counter has to reach BIN_W, so it needs enough bits for BIN_W itself.
   function automatic int cnt_width(input int bin_w);
      return $clog2(bin_w + 1);
   endfunction

endpackage

// File: rtl/bcd2binary_seq_if.sv
// -----------------------------------------------------------------------------
// bcd2binary_seq_if
// Start/ready/done handshake bundle between the entry logic (master) and the
// converter (slave).
//   start     : master -> slave, request a conversion (honoured when ready=1)
//   bcd       : master -> slave, packed BCD, bcd[3:0] = ones digit
//   ready     : slave -> master, converter idle
//   done_tick : slave -> master, one-cycle pulse, binary/err valid
//   binary    : slave -> master, converted value, held until next start
//   err       : slave -> master, input contained a digit above 9
// -----------------------------------------------------------------------------
interface bcd2binary_seq_if
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);

   logic                        start;
   logic [DIGITS*DIGIT_W-1:0]   bcd;
   logic                        ready;
   logic                        done_tick;
   logic [BIN_W-1:0]            binary;
   logic                        err;

   modport master (
      output start, bcd,
      input  ready, done_tick, binary, err
   );

   modport slave (
      input  start, bcd,
      output ready, done_tick, binary, err
   );

endinterface

// File: rtl/bcd2binary_seq_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// One-digit correction step of reverse double-dabble. After the combined
// register has been shifted right, a digit that picked up the LSB of its
// upper neighbour is worth 8 too much in its own weight (it should be 5),
// so digits at or above 8 have 3 subtracted.
//   digit_in  : 4-bit digit after the shift
//   digit_out : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   // NOTE: assign a default before any conditional update in always_comb so
   // every path drives the output and no latch is inferred.
   always_comb begin
      digit_out = digit_in;
      if (digit_in >= DIGIT_W'(ADJ_THRESH)) begin
         digit_out = digit_in - DIGIT_W'(ADJ_VAL);
      end
   end

endmodule

// File: rtl/bcd2binary_seq.sv
// -----------------------------------------------------------------------------
// bcd2binary_seq
// Sequential BCD-to-binary converter (reverse double-dabble). One iteration
// per clock: the {bcd, bin} pair is shifted right by one, then every BCD digit
// of 8 or more has 3 subtracted. After BIN_W iterations bin holds the value.
// Inputs with a digit above 9 are rejected immediately with err=1, binary=0.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of bcd2binary_seq_if (start, bcd, ready, done_tick,
//             binary, err)
// -----------------------------------------------------------------------------
module bcd2binary_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
)(
   input  logic            clk,
   input  logic            reset_n,
   bcd2binary_seq_if.slave bus
);

   localparam int BCD_W = DIGITS * DIGIT_W;
   localparam int CNT_W = cnt_width(BIN_W);
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);

   state_e             state_q,  state_d;
   logic [BCD_W-1:0]   bcd_q,    bcd_d;
   logic [BIN_W-1:0]   bin_q,    bin_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [BIN_W-1:0]   binary_q, binary_d;
   logic               err_q,    err_d;

   logic [BCD_W-1:0]   bcd_shift;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BIN_W-1:0]   bin_shift;
   logic               bcd_invalid;

   // Right shift of the concatenated {bcd_q, bin_q}: the BCD LSB moves into
   // the binary MSB and a zero enters at the top of the BCD register.
   always_comb begin
      bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
      bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
         .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   always_comb begin
      bcd_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.bcd[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
            bcd_invalid = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      bcd_d    = bcd_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      binary_d = binary_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bcd_invalid) begin
                  // Rejected input skips the iterations entirely.
                  binary_d = '0;
                  err_d    = 1'b1;
                  state_d  = DONE;
               end else begin
                  bcd_d   = bus.bcd;
                  bin_d   = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = CONV;
               end
            end
         end

         CONV: begin
            bcd_d = bcd_adj;
            bin_d = bin_shift;
            cnt_d = cnt_q + CNT_W'(1);
            // cnt_q counts completed iterations, so BIN_W-1 marks the last one;
            // the result is taken from the value being shifted in now.
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               binary_d = bin_shift;
               state_d  = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the working shift registers are reset as well, so a conversion
      // aborted by reset leaves no stale data behind.
      if (!reset_n) begin
         state_q  <= IDLE;
         bcd_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
         binary_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcd_q    <= bcd_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         binary_q <= binary_d;
         err_q    <= err_d;
      end
   end

   assign bus.ready     = (state_q == IDLE);
   assign bus.done_tick = (state_q == DONE);
   assign bus.binary    = binary_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2binary_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd2binary_seq
// Scoreboard bench for bcd2binary_seq. A watcher pushes the expected result of
// every accepted start (value from decimal arithmetic on the digits, err flag
// and the cycle done_tick must appear in); a monitor pops and compares on each
// done_tick and checks that binary/err hold while idle.
// -----------------------------------------------------------------------------
module tb_bcd2binary_seq;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;

   typedef struct {
      int value;
      int err;
      int done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   bcd2binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd2binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc       = 0;
   int   checks    = 0;
   int   errors    = 0;
   int   accepts   = 0;
   int   dones     = 0;
   int   first_acc = -1;
   int   last_acc  = -1;
   int   last_bin  = 0;
   int   last_err  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference: read the digits as plain numbers and form the decimal value.
   function automatic exp_t model(input logic [11:0] b, input int acc_cyc);
      exp_t e;
      int   v;
      int   d[3];
      v = int'(b);
      d[0] = v % 16;
      d[1] = (v / 16) % 16;
      d[2] = v / 256;
      e.err = (d[0] > 9 || d[1] > 9 || d[2] > 9) ? 1 : 0;
      e.value = (e.err != 0) ? 0 : d[2] * 100 + d[1] * 10 + d[0];
      e.done_cyc = acc_cyc + ((e.err != 0) ? 0 : BIN_W);
      return e;
   endfunction

   function automatic logic [11:0] to_bcd(input int n);
      return 12'((n / 100) * 256 + ((n / 10) % 10) * 16 + (n % 10));
   endfunction

   // Watcher: inputs are stable at the falling edge, so ready&&start here
   // means the next rising edge accepts this request.
   always @(negedge clk) begin
      if (reset_n && bus.ready === 1'b1 && bus.start === 1'b1) begin
         exp_q.push_back(model(bus.bcd, cyc + 1));
         accepts++;
         if (first_acc < 0) first_acc = cyc + 1;
         last_acc = cyc + 1;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.done_tick === 1'b1) begin
            dones++;
            check("ready_low_in_done", bus.ready, 0);
            if (exp_q.size() == 0) begin
               check("done_without_request", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               check("binary", bus.binary, mon_e.value);
               check("err", bus.err, mon_e.err);
               check("done_cycle", cyc, mon_e.done_cyc);
               last_bin = mon_e.value;
               last_err = mon_e.err;
            end
         end else if (bus.ready === 1'b1) begin
            check("binary_held", bus.binary, last_bin);
            check("err_held", bus.err, last_err);
         end
      end
   end

   // All driver steps run 1 time unit after a rising edge.
   task automatic wait_ready(input int budget);
      int n = 0;
      while (bus.ready !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: ready=%b after %0d cycles, expected 1", bus.ready, n);
      end
   endtask

   task automatic send(input logic [11:0] v);
      wait_ready(40);
      bus.bcd   = v;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || bus.ready !== 1'b1) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"},     bus.ready,     1);
      check({tag, "_done_tick"}, bus.done_tick, 0);
      check({tag, "_binary"},    bus.binary,    0);
      check({tag, "_err"},       bus.err,       0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.bcd   = '0;
      reset_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      send(12'h255); drain(40);
      send(12'h999); drain(40);
      send(12'h000); drain(40);
      send(12'h1A5); drain(40);
      send(12'h042); drain(40);

      // start and bcd changes during CONV must be ignored
      send(12'h321);
      repeat (3) begin @(posedge clk); #1; end
      bus.start = 1'b1;
      bus.bcd   = 12'h777;
      @(posedge clk); #1;
      bus.start = 1'b0;
      drain(40);

      // Reset in the middle of a conversion
      send(12'h500);
      repeat (5) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      check_reset_values("abort");
      accepts -= exp_q.size();
      exp_q.delete();
      last_bin = 0;
      last_err = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      send(12'h123); drain(40);

      // Random mix of valid and invalid inputs with random gaps
      repeat (40) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         send(12'($urandom_range(0, 4095)));
      end
      drain(40);

      // Exhaustive sweep with start held high: back-to-back acceptance
      first_acc = -1;
      bus.start = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         wait_ready(40);
         bus.bcd = to_bcd(i);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      drain(40);
      check("sweep_throughput", last_acc - first_acc, 999 * (BIN_W + 2));
      check("dones_match_accepts", dones, accepts);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
